// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash responder: FSM states, opcodes,
// frame field lengths and the little-endian byte-lane selector.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        FETCH,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;

    // Lane 0 is the least significant byte of the backing word.
    function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_flash_slave_if.sv
// SPI pad and backing-memory signals of the flash responder, with the SoC-side
// (master) and responder-side (slave) views.
interface spi_flash_slave_if #(
    parameter int MEM_AW = 22
);
    logic              spi_sck;
    logic              spi_ss;
    logic              spi_mosi;
    logic              spi_miso;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              cmd_err;

    modport master (
        output spi_sck, spi_ss, spi_mosi, mem_rdata,
        input  spi_miso, mem_req, mem_addr, cmd_err
    );

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, mem_rdata,
        output spi_miso, mem_req, mem_addr, cmd_err
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall strobes derived from the last two synchronized samples.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain_reg <= '0;
            prev_reg  <= 1'b0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], din};
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign rise = chain_reg[STAGES-1] & ~prev_reg;
    assign fall = ~chain_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_flash_slave.sv
// Oversampled SPI mode-0 flash responder serving READ (0x03) from a word-wide
// memory. Define SPI_FLASH_FAST_READ_EN to also accept FAST READ (0x0B).
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MEM_AW      = 22
) (
    input  logic             clock,
    input  logic             reset,
    spi_flash_slave_if.slave bus
);

    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   ss_sync;
    logic                   mosi_sync;
    logic                   sck_rise;
    logic                   sck_fall;

    // ss synchronizer resets to "deselected" so a reset never looks like a frame start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ss_sync_reg   <= '1;
            mosi_sync_reg <= '0;
        end else begin
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], bus.spi_ss};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.spi_mosi};
        end
    end

    assign ss_sync   = ss_sync_reg[SYNC_STAGES-1];
    assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];

    spi_sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sck_sync (
        .clock(clock),
        .reset(reset),
        .din  (bus.spi_sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    state_t                state_reg,     state_next;
    logic [4:0]            bit_cnt_reg,   bit_cnt_next;
    logic [CMD_BITS-2:0]   cmd_reg,       cmd_next;
    logic [ADDR_BITS-1:0]  byte_addr_reg, byte_addr_next;
    logic [31:0]           word_reg,      word_next;
    logic [7:0]            out_byte_reg,  out_byte_next;
    logic [2:0]            bit_idx_reg,   bit_idx_next;
    logic                  miso_reg,      miso_next;
    logic                  mem_req_reg,   mem_req_next;
    logic [MEM_AW-1:0]     mem_addr_reg,  mem_addr_next;
    logic                  cmd_err_reg,   cmd_err_next;
    logic                  rd_pend_reg,   rd_pend_next;
`ifdef SPI_FLASH_FAST_READ_EN
    logic                  fast_reg,      fast_next;
`endif

    logic [7:0]            opcode;
    logic [ADDR_BITS-1:0]  addr_shift;
    logic [ADDR_BITS-1:0]  addr_inc;

    // The opcode's last bit is still on mosi when the 8th rise is seen.
    assign opcode     = {cmd_reg, mosi_sync};
    assign addr_shift = {byte_addr_reg[ADDR_BITS-2:0], mosi_sync};
    assign addr_inc   = byte_addr_reg + 24'd1;

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        cmd_next       = cmd_reg;
        byte_addr_next = byte_addr_reg;
        word_next      = word_reg;
        out_byte_next  = out_byte_reg;
        bit_idx_next   = bit_idx_reg;
        miso_next      = miso_reg;
        mem_req_next   = 1'b0;
        mem_addr_next  = mem_addr_reg;
        cmd_err_next   = 1'b0;
        rd_pend_next   = mem_req_reg;
`ifdef SPI_FLASH_FAST_READ_EN
        fast_next      = fast_reg;
`endif

        if (ss_sync) begin
            // Deselect beats any same-cycle sck edge and drops an in-flight fetch.
            state_next   = IDLE;
            miso_next    = 1'b0;
            rd_pend_next = 1'b0;
            bit_cnt_next = '0;
        end else begin
            if (rd_pend_reg) begin
                word_next     = bus.mem_rdata;
                out_byte_next = word_lane(bus.mem_rdata, byte_addr_reg[1:0]);
            end

            case (state_reg)
                IDLE: begin
                    miso_next    = 1'b0;
                    bit_cnt_next = '0;
`ifdef SPI_FLASH_FAST_READ_EN
                    fast_next    = 1'b0;
`endif
                    state_next   = CMD;
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_next     = opcode[CMD_BITS-2:0];
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'(CMD_BITS - 1)) begin
                            bit_cnt_next = '0;
                            if (opcode == OP_READ) begin
                                state_next = ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                            end else if (opcode == OP_FAST_READ) begin
                                fast_next  = 1'b1;
                                state_next = ADDR;
`endif
                            end else begin
                                cmd_err_next = 1'b1;
                                state_next   = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        byte_addr_next = addr_shift;
                        bit_cnt_next   = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'(ADDR_BITS - 1)) begin
                            bit_cnt_next  = '0;
                            mem_req_next  = 1'b1;
                            mem_addr_next = addr_shift[MEM_AW+1:2];
`ifdef SPI_FLASH_FAST_READ_EN
                            state_next    = fast_reg ? DUMMY : FETCH;
`else
                            state_next    = FETCH;
`endif
                        end
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                DUMMY: begin
                    // The word fetched at the last address rise lands during these clocks.
                    if (sck_rise) begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'(DUMMY_BITS - 1)) begin
                            bit_cnt_next = '0;
                            bit_idx_next = 3'd7;
                            state_next   = DATA;
                        end
                    end
                end
`endif
                FETCH: begin
                    if (rd_pend_reg) begin
                        bit_idx_next = 3'd7;
                        state_next   = DATA;
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        miso_next    = out_byte_reg[bit_idx_reg];
                        bit_idx_next = bit_idx_reg - 3'd1;
                        if (bit_idx_reg == 3'd0) begin
                            byte_addr_next = addr_inc;
                            if (addr_inc[1:0] == 2'b00) begin
                                mem_req_next  = 1'b1;
                                mem_addr_next = addr_inc[MEM_AW+1:2];
                            end else begin
                                out_byte_next = word_lane(word_reg, addr_inc[1:0]);
                            end
                        end
                    end
                end
                IGNORE: begin
                    miso_next = 1'b0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            cmd_reg       <= '0;
            byte_addr_reg <= '0;
            word_reg      <= '0;
            out_byte_reg  <= '0;
            bit_idx_reg   <= '0;
            miso_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            cmd_err_reg   <= 1'b0;
            rd_pend_reg   <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_reg      <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            cmd_reg       <= cmd_next;
            byte_addr_reg <= byte_addr_next;
            word_reg      <= word_next;
            out_byte_reg  <= out_byte_next;
            bit_idx_reg   <= bit_idx_next;
            miso_reg      <= miso_next;
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            cmd_err_reg   <= cmd_err_next;
            rd_pend_reg   <= rd_pend_next;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_reg      <= fast_next;
`endif
        end
    end

    assign bus.spi_miso = miso_reg;
    assign bus.mem_req  = mem_req_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Bench for spi_flash_slave: a bit-level SPI master plus a sparse word memory,
// checked against a byte-address reference model of the flash contents.
module tb_spi_flash_slave;

    localparam int MEM_AW = 22;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    spi_flash_slave_if #(.MEM_AW(MEM_AW)) bus ();

    spi_flash_slave #(
        .SYNC_STAGES(2),
        .MEM_AW     (MEM_AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Sparse flash image: unwritten words read back as a fixed hash of the address.
    logic [31:0] mem_aa [int unsigned];

    function automatic logic [31:0] mem_word(input int unsigned wa);
        if (mem_aa.exists(wa)) return mem_aa[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A17_C3E5;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        logic [31:0] w;
        logic [31:0] s;
        w = mem_word(32'(a[23:2]));
        s = w >> (8 * a[1:0]);
        return s[7:0];
    endfunction

    // Memory responder and frame observers, sampled away from the active edge.
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_word  = '0;
    int unsigned req_addr_q[$];
    int          req_fall_q[$];
    int          err_rise_q[$];
    logic [7:0]  rx_q[$];
    int          miso_ones  = 0;
    int          data_falls = 0;
    int          rises      = 0;
    int          hp         = 4;

    always @(negedge clock) begin
        rsp_valid = bus.mem_req;
        if (bus.mem_req === 1'b1) begin
            rsp_word = mem_word(32'(bus.mem_addr));
            req_addr_q.push_back(32'(bus.mem_addr));
            req_fall_q.push_back(data_falls);
        end
        if (bus.cmd_err === 1'b1) err_rise_q.push_back(rises);
        if (bus.spi_ss === 1'b0 && bus.spi_miso === 1'b1) miso_ones++;
    end

    always @(posedge clock) bus.mem_rdata <= rsp_valid ? rsp_word : $urandom();

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One SPI mode-0 frame. limit >= 0 truncates it to that many sck cycles;
    // do_reset pulses reset before ss is released.
    task automatic run_frame(input logic [7:0] op, input logic [23:0] addr, input int dummy,
                             input int nbytes, input int limit, input bit do_reset);
        logic [7:0] rx;
        logic       b;
        int         total;
        rx = '0;
        rx_q.delete();
        req_addr_q.delete();
        req_fall_q.delete();
        err_rise_q.delete();
        miso_ones  = 0;
        data_falls = 0;
        rises      = 0;
        total = 32 + dummy + 8 * nbytes;
        if (limit >= 0 && limit < total) total = limit;
        hp = int'($urandom_range(4, 6));
        bus.spi_ss = 1'b0;
        wait_clk(hp);
        for (int i = 0; i < total; i++) begin
            if (i < 8)       b = op[7-i];
            else if (i < 32) b = addr[31-i];
            else             b = 1'($urandom_range(0, 1));
            bus.spi_mosi = b;
            wait_clk(hp);
            if (i >= 32 + dummy) begin
                rx = {rx[6:0], bus.spi_miso};
                if (((i - 32 - dummy) % 8) == 7) rx_q.push_back(rx);
            end
            bus.spi_sck = 1'b1;
            rises++;
            wait_clk(hp);
            bus.spi_sck = 1'b0;
            if (i >= 31 + dummy) data_falls++;
        end
        wait_clk(hp);
        if (do_reset) begin
            reset = 1'b0;
            #1;
            check("rst_mid_miso", 32'(bus.spi_miso), 32'd0);
            check("rst_mid_req", 32'(bus.mem_req), 32'd0);
            check("rst_mid_state", 32'(dut.state_reg), 32'(spi_flash_pkg::IDLE));
            wait_clk(1);
            reset = 1'b1;
            wait_clk(2);
        end
        bus.spi_ss = 1'b1;
        wait_clk(hp + 4);
    endtask

    // Data bytes plus the fetch sequence implied by the address walk: one fetch
    // at the end of the address, then one for every byte advance onto a word boundary.
    task automatic check_frame(input string tag, input logic [23:0] addr, input int nbytes);
        int unsigned exp_a[$];
        int          exp_f[$];
        logic [23:0] a;
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(nbytes));
        for (int k = 0; k < nbytes && k < rx_q.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), 32'(rx_q[k]), 32'(ref_byte(24'(addr + 24'(k)))));
        exp_a.push_back(32'(addr[23:2]));
        exp_f.push_back(0);
        for (int k = 1; k <= nbytes; k++) begin
            a = 24'(addr + 24'(k));
            if (a[1:0] == 2'b00) begin
                exp_a.push_back(32'(a[23:2]));
                exp_f.push_back(8 * k);
            end
        end
        check({tag, "_nreq"}, 32'(req_addr_q.size()), 32'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && k < req_addr_q.size(); k++) begin
            check($sformatf("%s_req%0d_addr", tag, k), req_addr_q[k], exp_a[k]);
            check($sformatf("%s_req%0d_fall", tag, k), 32'(req_fall_q[k]), 32'(exp_f[k]));
        end
        check({tag, "_cmd_err"}, 32'(err_rise_q.size()), 32'd0);
        $display("frame %s addr=%06h bytes=%0d reqs=%0d", tag, addr, nbytes, req_addr_q.size());
    endtask

    initial begin
        logic [23:0] ra;
        int          rn;
        bus.spi_sck  = 1'b0;
        bus.spi_ss   = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(3);
        check("rst_miso", 32'(bus.spi_miso), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_state", 32'(dut.state_reg), 32'(spi_flash_pkg::IDLE));
        reset = 1'b1;
        wait_clk(5);

        mem_aa[0] = 32'h4433_2211;
        run_frame(8'h03, 24'h000000, 0, 4, -1, 1'b0);
        check_frame("word0", 24'h000000, 4);
        check("word0_first", 32'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 32'h11);

        mem_aa[0] = 32'hAABB_CCDD;
        mem_aa[1] = 32'h8765_4321;
        run_frame(8'h03, 24'h000003, 0, 2, -1, 1'b0);
        check_frame("cross", 24'h000003, 2);

        mem_aa[32'h3F_FFFF] = $urandom();
        run_frame(8'h03, 24'hFFFFFF, 0, 2, -1, 1'b0);
        check_frame("wrap", 24'hFFFFFF, 2);

        run_frame(8'h9F, 24'($urandom()), 0, 1, -1, 1'b0);
        check("bad_op_err_cnt", 32'(err_rise_q.size()), 32'd1);
        check("bad_op_err_rise", 32'(err_rise_q.size() > 0 ? err_rise_q[0] : -1), 32'd8);
        check("bad_op_miso", 32'(miso_ones), 32'd0);
        check("bad_op_req", 32'(req_addr_q.size()), 32'd0);
        $display("frame bad_op err=%0d miso_ones=%0d", err_rise_q.size(), miso_ones);

        ra = 24'($urandom());
        run_frame(8'h03, ra, 0, 3, -1, 1'b0);
        check_frame("after_bad", ra, 3);

`ifdef SPI_FLASH_FAST_READ_EN
        mem_aa[0] = 32'h4433_2211;
        run_frame(8'h0B, 24'h000000, 8, 2, -1, 1'b0);
        check_frame("fast", 24'h000000, 2);
`else
        run_frame(8'h0B, 24'h000000, 0, 1, -1, 1'b0);
        check("fast_off_err", 32'(err_rise_q.size()), 32'd1);
        check("fast_off_miso", 32'(miso_ones), 32'd0);
        $display("frame fast_off err=%0d", err_rise_q.size());
`endif

        run_frame(8'h03, 24'h000004, 0, 0, 8 + 12, 1'b0);
        check("abort_req", 32'(req_addr_q.size()), 32'd0);
        $display("frame abort reqs=%0d", req_addr_q.size());
        run_frame(8'h03, 24'h000004, 0, 4, -1, 1'b0);
        check_frame("post_abort", 24'h000004, 4);

        ra = 24'($urandom());
        run_frame(8'h03, ra, 0, 4, 32 + 12, 1'b1);
        $display("frame reset_mid addr=%06h", ra);
        ra = 24'($urandom());
        run_frame(8'h03, ra, 0, 3, -1, 1'b0);
        check_frame("post_reset", ra, 3);

        for (int t = 0; t < 6; t++) begin
            ra = 24'($urandom());
            rn = int'($urandom_range(1, 5));
            run_frame(8'h03, ra, 0, rn, -1, 1'b0);
            check_frame($sformatf("rand%0d", t), ra, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
